// File: rtl/sequential_divider_8bit.sv
// sequential_divider_8bit: multi-cycle unsigned restoring divider with Run/Done handshake
module sequential_divider_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             Div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;
  state_t           state, state_nx;
  logic [WIDTH-1:0] q, d, q_nx;
  logic [WIDTH:0]   r, r_nx;
  logic [WIDTH+1:0] s, t;
  logic [CW-1:0]    cnt;
  logic             ge, last;
  // one restoring step: shift in the next dividend bit, trial-subtract D as add of ~D with carry-in
  // r's MSB is always 0 (r < D), so s never loses a bit and the sign of t is exact
  always_comb begin
    s    = {r, q[WIDTH-1]};
    t    = s + {2'b11, ~d} + {{(WIDTH+1){1'b0}}, 1'b1};
    ge   = ~t[WIDTH+1];
    r_nx = ge ? t[WIDTH:0] : s[WIDTH:0];
    q_nx = {q[WIDTH-2:0], ge};
    last = cnt == CW'(WIDTH - 1);
  end
  // state register
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  // next state: a held Run never restarts because DONE only leaves when Run drops
  always_comb begin
    state_nx = (state == IDLE) ? (Run ? LOAD : IDLE) :
               (state == LOAD) ? ((Divisor == '0) ? DONE : CALC) :
               (state == CALC) ? (last ? DONE : CALC) :
               (Run ? DONE : IDLE);
  end
  // status outputs decoded from state
  always_comb begin
    Busy = (state == LOAD) || (state == CALC);
    Done = state == DONE;
  end
  // datapath: results are written only on entry to DONE, never during CALC
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      q           <= '0;
      d           <= '0;
      r           <= '0;
      cnt         <= '0;
      Quotient    <= '0;
      Remainder   <= '0;
      Div_by_zero <= 1'b0;
    end else if (state == LOAD) begin
      q           <= Dividend;
      d           <= Divisor;
      r           <= '0;
      cnt         <= '0;
      Div_by_zero <= Divisor == '0;
      if (Divisor == '0) begin
        Quotient  <= '1;
        Remainder <= Dividend;
      end
    end else if (state == CALC) begin
      q   <= q_nx;
      r   <= r_nx;
      cnt <= cnt + CW'(1);
      if (last) begin
        Quotient  <= q_nx;
        Remainder <= r_nx[WIDTH-1:0];
      end
    end
endmodule

// File: tb/tb_sequential_divider_8bit.sv
// tb_sequential_divider_8bit: scoreboard bench for the restoring divider
module tb_sequential_divider_8bit;
  logic        Clk = 1'b0, clk_en = 1'b0;
  logic        Reset_n = 1'b1, Run = 1'b0;
  logic [7:0]  Dividend = '0, Divisor = '0;
  logic [7:0]  Quotient, Remainder;
  logic        Busy, Done, Div_by_zero;
  int          n_vec = 0, n_err = 0;
  logic [16:0] exp_q[$];
  logic [16:0] mon_e;
  logic        done_q = 1'b0;

  sequential_divider_8bit #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run),
    .Dividend(Dividend), .Divisor(Divisor),
    .Quotient(Quotient), .Remainder(Remainder),
    .Busy(Busy), .Done(Done), .Div_by_zero(Div_by_zero)
  );

  initial forever #5 if (clk_en) Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er, input logic ez);
    Dividend = a;
    Divisor  = b;
    Run      = 1'b1;
    exp_q.push_back({eq, er, ez});
  endtask

  task automatic wait_done();
    for (int k = 0; k < 20 && !Done; k++) tick();
    chk("done_timeout", Done, 1);
  endtask

  task automatic release_run();
    Run = 1'b0;
    tick();
    chk("done_fall", Done, 0);
    chk("busy_idle", Busy, 0);
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b,
                    input logic [7:0] eq, input logic [7:0] er);
    issue(a, b, eq, er, 1'b0);
    wait_done();
    release_run();
  endtask

  // monitor: compare results against the scoreboard on every rising Done
  always @(negedge Clk) begin
    if (Done && !done_q) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: q=%0d r=%0d with empty scoreboard", Quotient, Remainder);
      end else begin
        mon_e = exp_q.pop_front();
        chk("quotient", Quotient, mon_e[16:9]);
        chk("remainder", Remainder, mon_e[8:1]);
        chk("div_by_zero", Div_by_zero, mon_e[0]);
      end
    end
    done_q = Done;
  end

  initial begin
    #5 Reset_n = 1'b0;
    #1;
    chk("rst_quotient", Quotient, 0);
    chk("rst_remainder", Remainder, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_dbz", Div_by_zero, 0);
    Reset_n = 1'b1;
    #4 clk_en = 1'b1;
    repeat (20) begin
      tick();
      chk("idle_outputs", {Quotient, Remainder, Busy, Done, Div_by_zero}, 0);
    end
    // 200/7 with latency checks
    issue(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
    tick();
    chk("busy_e0", Busy, 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("busy_calc", Busy, 1);
      chk("done_early", Done, 0);
    end
    tick();
    chk("done_e9", Done, 1);
    chk("busy_e9", Busy, 0);
    release_run();
    chk("held_quotient", Quotient, 28);
    chk("held_remainder", Remainder, 4);
    // boundaries
    op(8'd255, 8'd1, 8'd255, 8'd0);
    op(8'd255, 8'd255, 8'd1, 8'd0);
    op(8'd5, 8'd9, 8'd0, 8'd5);
    op(8'd0, 8'd3, 8'd0, 8'd0);
    op(8'd128, 8'd2, 8'd64, 8'd0);
    // divide by zero
    issue(8'd77, 8'd0, 8'hFF, 8'd77, 1'b1);
    tick();
    chk("dbz_done_e0", Done, 0);
    tick();
    chk("dbz_done_e1", Done, 1);
    chk("dbz_busy_e1", Busy, 0);
    release_run();
    op(8'd100, 8'd10, 8'd10, 8'd0);
    // input and Run changes mid-operation are ignored
    issue(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
    repeat (5) tick();
    Dividend = 8'd9;
    Divisor  = 8'd2;
    Run      = 1'b0;
    for (int i = 5; i <= 8; i++) begin
      tick();
      chk("midchg_busy", Busy, 1);
    end
    tick();
    chk("midchg_done_e9", Done, 1);
    tick();
    chk("midchg_idle_e10", Done, 0);
    chk("midchg_busy_e10", Busy, 0);
    // held Run never restarts
    issue(8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
    wait_done();
    repeat (10) begin
      tick();
      chk("hold_done", Done, 1);
      chk("hold_busy", Busy, 0);
    end
    release_run();
    // reset mid-CALC aborts with no partial result
    Dividend = 8'd255;
    Divisor  = 8'd1;
    Run      = 1'b1;
    repeat (6) tick();
    chk("pre_rst_busy", Busy, 1);
    #2 Reset_n = 1'b0;
    #1;
    chk("midrst_quotient", Quotient, 0);
    chk("midrst_remainder", Remainder, 0);
    chk("midrst_busy", Busy, 0);
    chk("midrst_done", Done, 0);
    exp_q.push_back({8'd255, 8'd0, 1'b0});
    @(negedge Clk);
    Reset_n = 1'b1;
    wait_done();
    release_run();
    // sweep
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      op(a, b, a / b, a % b);
    end
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
